// File: rtl/midi_pkg.sv
// midi_pkg: shared definitions for the MIDI receiver.
//   - Wishbone register offsets (word index, wb_adr_i[3:2]) and STATUS bit positions
//   - receiver FSM state enum
//   - FIFO entry layout
//   - midi_data_count(): data bytes that follow a status byte (0 = not a channel message)
package midi_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_FERR      = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] d1;
    logic [7:0] d2;
  } midi_msg_t;

  function automatic logic [1:0] midi_data_count(input logic [7:0] st);
    case (st[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: return 2'd2;
      4'hC, 4'hD:                   return 2'd1;
      default:                      return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 serial receiver.
//   clk, rst      : system clock, async active-low reset
//   rxd           : raw serial input, idle high, asynchronous to clk
//   rx_byte       : received byte, valid while byte_valid is high
//   byte_valid    : 1-cycle pulse, one cycle after a good stop-bit sample
//   ferr_pulse    : 1-cycle pulse when the stop bit samples low (byte dropped)
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int DIV = 3200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       ferr_pulse
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  logic [1:0]    sync;
  logic          rxd_q;
  logic          rxd_s;
  logic          fall;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign rxd_s = sync[1];
  assign fall  = rxd_q & ~rxd_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync       <= 2'b11;
      rxd_q      <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      ferr_pulse <= 1'b0;
    end else begin
      sync       <= {sync[0], rxd};
      rxd_q      <= rxd_s;
      byte_valid <= 1'b0;
      ferr_pulse <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        // Re-check the line at mid start bit; a high line means it was a glitch.
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Sampling point is now mid-bit; take one sample every DIV cycles, LSB first.
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rxd_s, shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Return to IDLE right at the stop sample so a back-to-back start edge is caught.
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rxd_s) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
            end else begin
              ferr_pulse <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb_midi_rx.sv
// wb_midi_rx: Wishbone MIDI receiver with running-status parser and message FIFO.
//   clk, rst        : system clock, async active-low reset
//   wb_*            : Wishbone slave (full-word access, wb_adr_i[3:2] decoded)
//                     0 STATUS  [0] not_empty [1] full [2] ovf [3] ferr [12:8] count, W1C on 2/3
//                     1 DATA    read {8'h00,status,d1,d2} and pop; 0 when empty
//                     2 CTRL    [0] ie
//   midi_rxd        : serial input, 31250 8N1 by default
//   intr            : registered ie & not_empty
module wb_midi_rx
  import midi_pkg::*;
#(
  parameter int clk_freq   = 100000000,
  parameter int baud       = 31250,
  parameter int fifo_depth = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic        midi_rxd,
  output logic        intr
);

  localparam int DIV  = clk_freq / baud;
  localparam int AW   = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CNTW = AW + 1;

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       ferr_pulse;

  midi_uart_rx #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (midi_rxd),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .ferr_pulse (ferr_pulse)
  );

  // Parser: rs is the running status (bit7 = 0 means none), idx counts stored data bytes.
  logic [7:0] rs;
  logic [7:0] d1;
  logic       idx;
  logic [1:0] need;
  logic       push;
  midi_msg_t  push_msg;

  assign need = midi_data_count(rs);

  always_comb begin
    push     = 1'b0;
    push_msg = '0;
    if (byte_valid && !rx_byte[7] && rs[7]) begin
      if (idx) begin
        push     = 1'b1;
        push_msg = '{status: rs, d1: d1, d2: rx_byte};
      end else if (need == 2'd1) begin
        push     = 1'b1;
        push_msg = '{status: rs, d1: rx_byte, d2: 8'h00};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs  <= '0;
      d1  <= '0;
      idx <= 1'b0;
    end else if (byte_valid) begin
      if (rx_byte[7:3] == 5'b11111) begin
        // realtime: transparent to running status and partial message
      end else if (rx_byte[7:4] == 4'hF) begin
        rs  <= '0;
        idx <= 1'b0;
      end else if (rx_byte[7]) begin
        rs  <= rx_byte;
        idx <= 1'b0;
      end else if (rs[7]) begin
        if (idx || need == 2'd1) begin
          idx <= 1'b0;
        end else begin
          d1  <= rx_byte;
          idx <= 1'b1;
        end
      end
    end
  end

  // Wishbone decode; side effects land on the edge that raises ack.
  logic       req, wr, rd, pop;
  logic [1:0] adr;
  assign req = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr  = req & wb_we_i;
  assign rd  = req & ~wb_we_i;
  assign adr = wb_adr_i[3:2];

  // FIFO
  midi_msg_t       mem [fifo_depth];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            not_empty, full, do_push;
  logic [4:0]      count5;

  assign not_empty = (count != '0);
  assign full      = (count == CNTW'(fifo_depth));
  assign pop       = rd & (adr == REG_DATA) & not_empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_push   = push & (~full | pop);
  assign count5    = 5'(count);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_msg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= AW'((wr_ptr + 1'b1) % fifo_depth);
      if (pop)     rd_ptr <= AW'((rd_ptr + 1'b1) % fifo_depth);
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Registers
  logic        ie, ovf, ferr;
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (adr)
      REG_STATUS: begin
        rdata[ST_NOT_EMPTY]       = not_empty;
        rdata[ST_FULL]            = full;
        rdata[ST_OVF]             = ovf;
        rdata[ST_FERR]            = ferr;
        rdata[ST_COUNT_LSB +: 5]  = count5;
      end
      REG_DATA: if (not_empty) rdata = {8'h00, mem[rd_ptr]};
      REG_CTRL: rdata[0] = ie;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie       <= 1'b0;
      ovf      <= 1'b0;
      ferr     <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      intr     <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= rd ? rdata : 32'h0;
      intr     <= ie & not_empty;
      if (wr && adr == REG_CTRL) ie <= wb_dat_i[0];
      // New events win over a simultaneous clear so none is lost.
      if (push && full && !pop)                              ovf <= 1'b1;
      else if (wr && adr == REG_STATUS && wb_dat_i[ST_OVF])  ovf <= 1'b0;
      if (ferr_pulse)                                        ferr <= 1'b1;
      else if (wr && adr == REG_STATUS && wb_dat_i[ST_FERR]) ferr <= 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_dat_i[31:4], wb_adr_i[31:4], wb_adr_i[1:0]};

endmodule

// File: tb/tb_wb_midi_rx.sv
module tb_wb_midi_rx;

  localparam int CLK_FREQ = 2000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = CLK_FREQ / BAUD;  // 20 cycles per bit

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_we_i  = 1'b0;
  logic        wb_ack_o;
  logic        midi_rxd = 1'b1;
  logic        intr;

  int n_tests = 0;
  int n_fail  = 0;

  wb_midi_rx #(.clk_freq(CLK_FREQ), .baud(BAUD), .fifo_depth(8)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .midi_rxd(midi_rxd), .intr(intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] wd,
                         output logic [31:0] rdv);
    logic got;
    got = 1'b0;
    rdv = 32'hDEADBEEF;
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
    wb_adr_i = {28'h0, a, 2'b00}; wb_dat_i = wd;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (wb_ack_o) begin got = 1'b1; rdv = wb_dat_o; end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $error("FAIL wb_timeout: observed no ack expected ack within 8 cycles");
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    wb_xfer(1'b0, a, 32'h0, v);
    check(tag, v, exp);
  endtask

  task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] v;
    wb_xfer(1'b1, a, d, v);
  endtask

  // Start bit plus 8 data bits; returns at the negedge where the stop bit begins.
  task automatic send_head(input logic [7:0] b);
    midi_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_head(b);
    midi_rxd = stop;
    repeat (DIV) @(negedge clk);
    midi_rxd = 1'b1;
  endtask

  initial begin
    logic [31:0] exp;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_intr", {31'h0, intr}, 32'h0);
    rst = 1'b1;
    repeat (DIV) @(negedge clk);
    wb_rd(2'd0, 32'h0, "rst_status");
    wb_rd(2'd2, 32'h0, "rst_ctrl");
    wb_rd(2'd1, 32'h0, "empty_data");
    @(negedge clk);
    check("ack_one_cycle", {31'h0, wb_ack_o}, 32'h0);

    // Basic note-on
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
    wb_rd(2'd0, 32'h0000_0101, "status_one");
    wb_rd(2'd1, 32'h0090_3C64, "note_on");
    wb_rd(2'd0, 32'h0, "status_drained");

    // Running status
    send_byte(8'h90, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h7F, 1'b1);
    send_byte(8'h40, 1'b1); send_byte(8'h00, 1'b1);
    wb_rd(2'd1, 32'h0090_407F, "rs_msg1");
    wb_rd(2'd1, 32'h0090_4000, "rs_msg2");

    // Program change, then realtime byte inside a note-on
    send_byte(8'hC0, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h90, 1'b1); send_byte(8'hF8, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
    wb_rd(2'd1, 32'h00C0_0500, "prog_change");
    wb_rd(2'd1, 32'h0090_3C64, "realtime_transparent");

    // System common clears running status; its data is discarded
    send_byte(8'hF0, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h40, 1'b1);
    wb_rd(2'd0, 32'h0, "sysex_discard");

    // DATA writes ignored, register 3 reads 0
    wb_wr(2'd1, 32'h1234_5678);
    wb_rd(2'd0, 32'h0, "data_write_ignored");
    wb_rd(2'd3, 32'h0, "reg3_zero");

    // Overflow: 9 messages into an 8-deep FIFO
    for (int i = 0; i < 9; i++) begin
      send_byte(8'h90, 1'b1); send_byte(8'(i), 1'b1); send_byte(8'h40, 1'b1);
    end
    wb_rd(2'd0, 32'h0000_0807, "ovf_status");
    wb_wr(2'd0, 32'h4);
    wb_rd(2'd0, 32'h0000_0803, "ovf_cleared");
    for (int i = 0; i < 8; i++) begin
      exp = {16'h0090, 8'(i), 8'h40};
      wb_rd(2'd1, exp, "ovf_entry");
    end
    wb_rd(2'd0, 32'h0, "ovf_ninth_absent");

    // Framing error
    send_byte(8'h90, 1'b0);
    repeat (DIV) @(negedge clk);
    wb_rd(2'd0, 32'h0000_0008, "ferr_set");
    send_byte(8'h3C, 1'b1);
    wb_rd(2'd0, 32'h0000_0008, "ferr_lone_data");
    wb_wr(2'd0, 32'h8);
    wb_rd(2'd0, 32'h0, "ferr_cleared");

    // Interrupt timing: stop sample lands 12.5 cycles into the stop bit,
    // intr is visible 3 cycles later.
    wb_wr(2'd2, 32'h1);
    wb_rd(2'd2, 32'h1, "ie_set");
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1);
    send_head(8'h64);
    midi_rxd = 1'b1;
    repeat (14) @(negedge clk);
    check("intr_not_yet", {31'h0, intr}, 32'h0);
    @(negedge clk);
    check("intr_rise", {31'h0, intr}, 32'h1);
    repeat (DIV - 15) @(negedge clk);

    // Reset in the middle of the next frame's data bits
    midi_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      midi_rxd = i[0];
      repeat (DIV) @(negedge clk);
    end
    rst = 1'b0;
    midi_rxd = 1'b1;
    #1;
    check("rst_intr_clear", {31'h0, intr}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    wb_rd(2'd0, 32'h0, "rst_fifo_empty");
    wb_rd(2'd2, 32'h0, "rst_ie_clear");
    send_byte(8'h64, 1'b1);
    wb_rd(2'd0, 32'h0, "rst_rs_cleared");
    send_byte(8'h80, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h00, 1'b1);
    wb_rd(2'd1, 32'h0080_3C00, "post_rst_msg");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Overall time bound
  initial begin
    #5000000;
    $display("FAIL timeout: observed no finish expected finish before 500000 cycles");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_midi_rx.md
# wb_midi_rx

Wishbone slave that receives the MIDI serial stream (31250 baud, 8N1) on a dedicated input pin. It parses channel-voice messages, including running status, and queues complete messages in a small FIFO for the LM32 to read. It is the receiving end of the MIDI link that the existing UART transmits on. It attaches to a free conbus slave port as a peer of the uart, timer, gpio and spi blocks, and raises a level interrupt while messages are pending.

## Interface
- clk_freq, 100000000, system clock in Hz
- baud, 31250, serial bit rate; bit period DIV = clk_freq/baud (3200 at defaults)
- fifo_depth, 8, message FIFO entries; power of two, 2..16
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- wb_adr_i  in  32  byte address; only [3:2] decoded
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_sel_i  in  4  byte selects, ignored (full-word access only)
- wb_stb_i, wb_cyc_i, wb_we_i  in  1  Wishbone strobe / cycle / write
- wb_ack_o  out  1  Wishbone acknowledge
- midi_rxd  in  1  serial input, idle high, asynchronous to clk
- intr  out  1  active-high interrupt request

## Operation
- midi_rxd passes through a 2-FF synchronizer; its reset value is 1.
- Receiver FSM: IDLE -> START on synchronized falling edge.
  - START: at DIV/2 cycles, if line still 0 go to DATA; else return to IDLE (glitch).
  - DATA: sample 8 bits LSB first, one every DIV cycles.
  - STOP: sample at DIV. Line 1 delivers the byte. Line 0 discards the byte and sets ferr. Both return to IDLE.
- Parser (runs on each delivered byte):
  - 0x80-0xEF: load running status, clear data index. Expected data count is 2 for high nibble 8,9,A,B,E and 1 for C,D.
  - 0xF0-0xF7: clear running status; following data bytes are discarded.
  - 0xF8-0xFF (realtime): ignored; running status and partial message are untouched.
  - Data byte (bit7=0) with no running status: discarded.
  - Data byte otherwise: stored. When the count is reached, push entry {status,d1,d2} (d2=0x00 for 1-byte messages) and clear the data index. Running status is kept.
- FIFO: 24-bit entries. Push when full drops the message and sets ovf. A push and a pop in the same cycle both occur, including when full.
- Registers, by wb_adr_i[3:2]:
  - 0 STATUS: [0] not_empty, [1] full, [2] ovf (sticky), [3] ferr (sticky), [12:8] count. Writing 1 to bit 2 or bit 3 clears that flag.
  - 1 DATA: read returns {8'h00,status,d1,d2} and pops. When empty it returns 0 and does not pop. Writes are ignored.
  - 2 CTRL: [0] ie (rw), other bits read 0.
  - 3: reads 0, writes ignored.
- intr = registered (ie & not_empty).

## Timing
- Reset values: wb_ack_o=0, wb_dat_o=0, intr=0. FIFO is empty, running status is cleared, ie/ovf/ferr=0, FSM is in IDLE.
- Wishbone: wb_ack_o rises the cycle after stb&cyc&~ack and is held for exactly one cycle. wb_dat_o is valid with ack. The pop or write side effect occurs on the ack cycle.
- Latency: the byte is delivered 1 cycle after the stop-bit sample. The FIFO entry and not_empty are visible 2 cycles after the stop sample. intr follows 1 cycle later.
- Full frame is 10*DIV cycles. The receiver re-arms in IDLE immediately after the stop sample, so back-to-back frames are received.
- Reset asserted mid-frame or mid-message aborts everything immediately. No partial message survives.

## Structure
- Package midi_pkg holds:
  - register offsets and STATUS bit positions
  - the receiver state enum (IDLE, START, DATA, STOP)
  - a function mapping status byte -> expected data count (0 = not a channel message)
- Sub-module midi_uart_rx holds the synchronizer, bit-rate counter and receiver FSM. Its outputs are byte[7:0], byte_valid (1-cycle pulse) and ferr_pulse.
- The parser, FIFO and Wishbone register file live in wb_midi_rx.

## Test plan
- Drive 0x90,0x3C,0x64 at 31250 baud, then read DATA -> 0x00903C64. A following STATUS read returns not_empty=0.
- Running status: drive 0x90,0x40,0x7F,0x40,0x00 -> two DATA reads return 0x0090407F, then 0x00904000.
- Drive 0xC0,0x05, then 0x90,0xF8,0x3C,0x64 -> reads return 0x00C00500, then 0x00903C64 (realtime byte is transparent).
- Overflow: send 9 note-on messages with depth 8 -> STATUS full=1, ovf=1, count=8, and the 9th message is absent. Writing STATUS=0x4 clears ovf.
- Framing error: send 0x90 with stop bit held 0 -> ferr=1 and no entry. A subsequent lone 0x3C is discarded and the FIFO stays empty.
- Set ie=1, send one message -> intr rises 3 cycles after the stop sample. Assert rst during the next frame's data bits -> intr=0 and the FIFO is empty. The next clean frame is received correctly.
